dmem_write_buffer: RTL and testbench

//  Data-memory responder on the CPU store/load port (memwrite, dataadr, writedata -> readdata).
//  - Stores are posted into a small FIFO; a drain FSM commits them to a word-addressed backing array at one entry per DRAIN_CYCLES+1 clocks.
//  - Loads read the array, with store-to-load forwarding from the FIFO.
//  - stall holds the CPU when a store arrives while the FIFO is full.

---
 rtl/dmem_write_buffer_if.sv | 12 +
 rtl/dmem_write_buffer.sv | 123 ++++++++++++
 tb/tb_dmem_write_buffer.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_write_buffer_if.sv
// CPU data-memory port bundle: store/load request from the CPU, load data and
// stall back from the memory side.
interface dmem_write_buffer_if;
  logic        memwrite;
  logic [31:0] dataadr;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        stall;

  modport master (output memwrite, dataadr, writedata, input readdata, stall);
  modport slave  (input memwrite, dataadr, writedata, output readdata, stall);
endinterface

// File: rtl/dmem_write_buffer.sv
// Data memory with a posted-store FIFO drained by a timed FSM, plus
// store-to-load forwarding from the queued entries.
module dmem_write_buffer #(
  parameter int ADDR_BITS    = 6,
  parameter int DEPTH        = 4,
  parameter int DRAIN_CYCLES = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  dmem_write_buffer_if.slave       bus,
  output logic [$clog2(DEPTH):0]   pending,
  output logic                     busy
);

  localparam int PW   = $clog2(DEPTH);
  localparam int CNTW = $clog2(DRAIN_CYCLES) + 1;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_WAIT   = 2'd1;
  localparam logic [1:0] S_COMMIT = 2'd2;

  localparam logic [PW:0]     FULL_CNT = (PW+1)'(DEPTH);
  localparam logic [PW:0]     ONE_CNT  = (PW+1)'(1);
  localparam logic [CNTW-1:0] RELOAD   = CNTW'(DRAIN_CYCLES - 1);

  logic [ADDR_BITS-1:0] r_addr [DEPTH];
  logic [31:0]          r_data [DEPTH];
  logic [31:0]          r_mem  [2**ADDR_BITS];
  logic [PW-1:0]        r_head;
  logic [PW-1:0]        r_tail;
  logic [PW:0]          r_count;
  logic [1:0]           r_state;
  logic [CNTW-1:0]      r_cnt;

  logic [ADDR_BITS-1:0] w_widx;
  logic                 w_full;
  logic                 w_empty;
  logic                 w_push;
  logic                 w_pop;
  logic [31:0]          w_rdata;
  logic                 w_unused_addr;

  assign w_widx        = bus.dataadr[ADDR_BITS+1:2];
  assign w_unused_addr = ^{bus.dataadr[31:ADDR_BITS+2], bus.dataadr[1:0]};
  assign w_full        = (r_count == FULL_CNT);
  assign w_empty       = (r_count == '0);
  assign w_push        = bus.memwrite & ~w_full;
  assign w_pop         = (r_state == S_COMMIT);

  // No pop bypass: a full FIFO stalls even on its commit edge.
  assign bus.stall = bus.memwrite & w_full;
  assign pending   = r_count;
  assign busy      = (r_state != S_IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_tail <= r_tail + 1'b1;
      if (w_pop)  r_head <= r_head + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_addr[r_tail] <= w_widx;
      r_data[r_tail] <= bus.writedata;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (!w_empty) begin
            r_state <= S_WAIT;
            r_cnt   <= RELOAD;
          end
        end
        S_WAIT: begin
          if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
          else             r_state <= S_COMMIT;
        end
        S_COMMIT: begin
          // A same-edge push keeps the queue non-empty after this pop.
          if ((r_count != ONE_CNT) || w_push) begin
            r_state <= S_WAIT;
            r_cnt   <= RELOAD;
          end else begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_pop) r_mem[r_addr[r_head]] <= r_data[r_head];
  end

  // Walk oldest to youngest so the youngest matching entry wins.
  always_comb begin
    w_rdata = r_mem[w_widx];
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (((PW+1)'(i) < r_count) && (r_addr[r_head + PW'(i)] == w_widx))
        w_rdata = r_data[r_head + PW'(i)];
    end
  end

  assign bus.readdata = w_rdata;

endmodule

// File: tb/tb_dmem_write_buffer.sv
// Scoreboard bench: two buffer configurations driven by randomized and directed
// store/load traffic, checked against a timing-level reference model.
module tb_dmem_write_buffer;

  logic       clk = 1'b0;
  logic       rst0, rst1;
  logic [2:0] pend0;
  logic [1:0] pend1;
  logic       busy0, busy1;

  dmem_write_buffer_if bus0 ();
  dmem_write_buffer_if bus1 ();

  dmem_write_buffer #(.ADDR_BITS(6), .DEPTH(4), .DRAIN_CYCLES(2)) u_dut0 (
    .clk(clk), .reset(rst0), .bus(bus0.slave), .pending(pend0), .busy(busy0));
  dmem_write_buffer #(.ADDR_BITS(6), .DEPTH(2), .DRAIN_CYCLES(1)) u_dut1 (
    .clk(clk), .reset(rst1), .bus(bus1.slave), .pending(pend1), .busy(busy1));

  always #5 clk = ~clk;

  typedef struct {
    logic        stall;
    int          pend;
    logic        busy;
    logic        rchk;
    logic [31:0] rd;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  exp_t me;
  int   tests = 0;
  int   fails = 0;

  // Reference model: queued stores as an ordered list, commit times as edge numbers.
  int          depth_k[2] = '{4, 2};
  int          drain_k[2] = '{2, 1};
  int          fa[2][8];
  logic [31:0] fd[2][8];
  int          fcnt[2];
  logic [31:0] mmem[2][64];
  bit          known[2][64];
  bit          sched[2];
  longint      nxt[2];
  longint      edge_n[2];

  task automatic drive(input int k, input logic mw, input logic [31:0] a,
                       input logic [31:0] d, input logic r);
    if (k == 0) begin
      bus0.memwrite = mw; bus0.dataadr = a; bus0.writedata = d; rst0 = r;
    end else begin
      bus1.memwrite = mw; bus1.dataadr = a; bus1.writedata = d; rst1 = r;
    end
  endtask

  task automatic edge_step(input int k, input logic mw, input int w,
                           input logic [31:0] d, input logic r);
    longint n;
    int     s;
    bit     popped;
    if (!r) return;
    edge_n[k]++;
    n      = edge_n[k];
    s      = fcnt[k];
    popped = sched[k] && (n == nxt[k]);
    if (popped) begin
      mmem[k][fa[k][0]]  = fd[k][0];
      known[k][fa[k][0]] = 1'b1;
      for (int i = 0; i < fcnt[k] - 1; i++) begin
        fa[k][i] = fa[k][i+1];
        fd[k][i] = fd[k][i+1];
      end
      fcnt[k]--;
    end
    if (mw && s < depth_k[k]) begin
      fa[k][fcnt[k]] = w;
      fd[k][fcnt[k]] = d;
      fcnt[k]++;
    end
    if (popped) begin
      if (fcnt[k] > 0) nxt[k] = n + drain_k[k] + 1;
      else             sched[k] = 1'b0;
    end else if (!sched[k] && s > 0) begin
      sched[k] = 1'b1;
      nxt[k]   = n + drain_k[k] + 1;
    end
  endtask

  // One clock: drive inputs, queue the expected response, advance the model.
  task automatic cyc(input int k, input logic mw, input logic [31:0] a,
                     input logic [31:0] d, input logic r, output logic st);
    exp_t e;
    int   w;
    w = int'(a[7:2]);
    drive(k, mw, a, d, r);
    if (!r) begin
      fcnt[k]  = 0;
      sched[k] = 1'b0;
    end
    e.stall = mw && (fcnt[k] == depth_k[k]);
    e.pend  = fcnt[k];
    e.busy  = sched[k];
    e.rchk  = known[k][w];
    e.rd    = mmem[k][w];
    for (int i = 0; i < fcnt[k]; i++)
      if (fa[k][i] == w) begin
        e.rchk = 1'b1;
        e.rd   = fd[k][i];
      end
    if (k == 0) q0.push_back(e);
    else        q1.push_back(e);
    st = e.stall;
    @(posedge clk);
    edge_step(k, mw, w, d, r);
    #1;
  endtask

  task automatic store(input int k, input logic [31:0] a, input logic [31:0] d);
    logic st;
    int   guard;
    st    = 1'b1;
    guard = 0;
    while (st && guard < 50) begin
      cyc(k, 1'b1, a, d, 1'b1, st);
      guard++;
    end
    if (st) begin
      tests++; fails++;
      $display("FAIL store_retry[dut%0d] got=stalled required=accepted", k);
    end
  endtask

  task automatic load(input int k, input logic [31:0] a);
    logic st;
    cyc(k, 1'b0, a, $urandom, 1'b1, st);
  endtask

  task automatic drain(input int k);
    int guard;
    guard = 0;
    while ((fcnt[k] > 0 || sched[k]) && guard < 100) begin
      load(k, 32'($urandom_range(0, 15)) << 2);
      guard++;
    end
  endtask

  task automatic run(input int k);
    logic        st;
    logic [31:0] r32;
    int          w;
    @(posedge clk);
    #1;
    cyc(k, 1'b0, 32'd0, 32'd0, 1'b0, st);
    cyc(k, 1'b0, 32'd84, 32'd0, 1'b0, st);
    // T1 forwarding
    store(k, 32'd84, 32'd7);
    repeat (5) load(k, 32'd84);
    // T2 full / stall
    for (int i = 0; i < 5; i++) store(k, 32'(4 * i), 32'(i + 1));
    drain(k);
    for (int i = 0; i < 5; i++) load(k, 32'(4 * i));
    // T3 same address
    store(k, 32'd80, 32'd5);
    store(k, 32'd80, 32'd9);
    repeat (8) load(k, 32'd80);
    // T4 reset before the commit edge
    store(k, 32'd84, 32'd3);
    drain(k);
    store(k, 32'd84, 32'd7);
    load(k, 32'd84);
    load(k, 32'd84);
    cyc(k, 1'b0, 32'd84, 32'd0, 1'b0, st);
    cyc(k, 1'b0, 32'd84, 32'd0, 1'b0, st);
    repeat (3) load(k, 32'd84);
    // T5 wrap with idle gaps
    for (int i = 0; i < 10; i++) begin
      store(k, 32'(4 * i), 32'(i));
      repeat ($urandom_range(0, 3)) load(k, 32'($urandom_range(0, 15)) << 2);
    end
    drain(k);
    for (int i = 0; i < 10; i++) load(k, 32'(4 * i));
    // Random traffic; ignored address bits carry garbage
    for (int i = 0; i < 300; i++) begin
      r32 = $urandom;
      w   = $urandom_range(0, 15);
      r32 = (r32 & ~32'h0000_00FC) | (32'(w) << 2);
      if ($urandom_range(0, 63) == 0) cyc(k, 1'b0, r32, 32'd0, 1'b0, st);
      else if ($urandom_range(0, 1) == 1) store(k, r32, $urandom);
      else load(k, r32);
    end
    drain(k);
    for (int i = 0; i < 16; i++) load(k, 32'(4 * i));
  endtask

  task automatic chk(input int k, input string nm, input logic [31:0] act,
                     input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s[dut%0d] got=%0h required=%0h at %0t", nm, k, act, req, $time);
    end
  endtask

  always @(negedge clk) begin
    if (q0.size() > 0) begin
      me = q0.pop_front();
      chk(0, "stall", 32'(bus0.stall), 32'(me.stall));
      chk(0, "pending", 32'(pend0), 32'(me.pend));
      chk(0, "busy", 32'(busy0), 32'(me.busy));
      if (me.rchk) chk(0, "readdata", bus0.readdata, me.rd);
    end
    if (q1.size() > 0) begin
      me = q1.pop_front();
      chk(1, "stall", 32'(bus1.stall), 32'(me.stall));
      chk(1, "pending", 32'(pend1), 32'(me.pend));
      chk(1, "busy", 32'(busy1), 32'(me.busy));
      if (me.rchk) chk(1, "readdata", bus1.readdata, me.rd);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout required=finish");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1);
  end

  initial begin
    for (int k = 0; k < 2; k++) begin
      fcnt[k]   = 0;
      sched[k]  = 1'b0;
      nxt[k]    = 0;
      edge_n[k] = 0;
      for (int j = 0; j < 64; j++) begin
        known[k][j] = 1'b0;
        mmem[k][j]  = '0;
      end
    end
    drive(0, 1'b0, 32'd0, 32'd0, 1'b0);
    drive(1, 1'b0, 32'd0, 32'd0, 1'b0);
    fork
      run(0);
      run(1);
    join
    @(negedge clk);
    @(negedge clk);
    if (q0.size() != 0 || q1.size() != 0) begin
      tests++; fails++;
      $display("FAIL scoreboard_drain got=%0d required=0", q0.size() + q1.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
